fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage of the multi-cycle Cortex-M0 core, sitting directly upstream of the control unit and decoder.
- Issues word reads to instruction memory and buffers the returned Thumb halfwords in a small queue.
- Presents one instruction at a time, plus its PC, to the decoder.
- Redirects on the control unit's branch strobe; the control unit's fetch-state strobe consumes each instruction.

Parameters:
- RESET_PC, 32'h0000_0000: fetch address after reset; bit0 ignored.
- QDEPTH, 4: halfword queue depth; power of two, >= 4.

Ports:
- clk, input, 1: core clock; all state on rising edge.
- rst, input, 1: asynchronous, active-low reset.
- branch, input, 1: redirect strobe, driven by the control unit's cu_branch.
- branch_target, input, 32: redirect address, sampled when branch=1.
- instr_ack, input, 1: decoder/control unit consumes the presented instruction (fetch state).
- imem_req, output, 1: read request.
- imem_addr, output, 32: word-aligned read address, bits[1:0]=0.
- imem_gnt, input, 1: request accepted this cycle.
- imem_rvalid, input, 1: read data valid.
- imem_rdata, input, 32: read data, little-endian (low halfword = lower address).
- instr_valid, output, 1: instr/instr_pc are valid.
- instr, output, 32: [15:0] first halfword; [31:16] second halfword for 32-bit forms, else 0.
- instr_is32, output, 1: presented instruction is 32-bit.
- instr_pc, output, 32: address of instr[15:0]; bit0=0.

Behaviour:
- Reset (rst=0, async): queue empty, imem_req=0, imem_addr=RESET_PC&~3, instr_pc=RESET_PC&~1, skip_low=RESET_PC[1], outstanding=0, drop=0, instr_valid=0, instr=0, instr_is32=0.
- Reset release mid-transaction: any late imem_rvalid while outstanding=0 is ignored.
- Request FSM, states IDLE, REQ, WAIT:
  - IDLE->REQ when free slots >= 2 and branch=0.
  - REQ holds imem_req=1 until imem_gnt. On gnt: ->WAIT, outstanding=1, imem_addr += 4 the next cycle.
  - WAIT->IDLE on imem_rvalid.
- At most one outstanding read. Memory latency >= 1 cycle after gnt, unbounded.
- Response push, on rvalid with drop=0:
  - Push imem_rdata[15:0] then [31:16].
  - If skip_low=1, push only [31:16], then clear skip_low.
- Space is reserved at request time, so a response never overflows the queue. Simultaneous pop and push in one cycle is legal.
- Output, combinational from queue head:
  - Head halfword prefix hw[15:11] in {11101, 11110, 11111} is 32-bit: instr_valid=1 only when >= 2 entries; instr_is32=1.
  - Otherwise instr_valid = (queue non-empty).
- Pop on instr_ack & instr_valid: remove 1 or 2 entries; instr_pc += 2 or 4 (mod 2^32 wrap).
- instr_ack while instr_valid=0 is ignored.
- Branch has priority over ack, push and grant in the same cycle. Next cycle:
  - queue empty; imem_addr=target&~3; instr_pc=target&~1; skip_low=target[1]; FSM->IDLE.
  - If a granted read is outstanding, set drop=1; the next rvalid is discarded, then drop=0.
  - If branch and rvalid coincide, that data is discarded and drop is not set.
  - An ungranted REQ is withdrawn. The memory samples only on req&gnt, so changing the address while ungranted is legal.
- Back-to-back branches: the latest target wins; drop stays set while one read is outstanding.
- instr_valid never asserts in the cycle after a branch.

Optional Feature:
FETCH_BL32_EN
- Defined: 32-bit prefix detection as above; BL/MSR/MRS/DMB-class pairs are presented together with instr_is32=1.
- Undefined: every halfword is presented alone, instr_is32 tied 0, instr[31:16]=0, pop always 1 entry, pc += 2.
- Undefined is the default build; the decoder then sequences 32-bit encodings itself.

Decomposition:
- Shared package cm0_pkg:
  - FSM state encoding (IDLE/REQ/WAIT, 2 bits).
  - Prefix constants for 32-bit detection.
  - Halfword width constant.
  - RESET_PC default.
- One natural sub-module: fetch_hw_queue.
  - Circular halfword FIFO, QDEPTH entries.
  - Push of 1 or 2 entries and pop of 1 or 2 entries per cycle.
  - Synchronous flush; count output.
- Wrap-around on pointer bits modulo QDEPTH.

Test Plan:
1. Reset, RESET_PC=0, memory returns 32'h4601_2000 at addr 0 (1-cycle latency) -> first req addr 0; instr=16'h2000 pc=0; after ack instr=16'h4601 pc=2; next req addr 4.
2. Decoder never acks -> after 2 words the queue is full (4 entries) and imem_req stays 0; first ack -> still no request until 2 slots are free.
3. branch with target 0x102 while a read is outstanding -> stale rvalid discarded; next req addr 0x100; only the high halfword of the 0x100 response is presented, pc=0x102.
4. Branch and rvalid in the same cycle -> data dropped, drop not set; next accepted data comes from the target.
5. FETCH_BL32_EN, word 32'hF800_F000 -> instr_valid=1, instr_is32=1, instr=32'hF800_F000, ack advances pc by 4. Undefined build -> two presentations, 16'hF000 then 16'hF800.
6. rst low asserted mid-WAIT, then released, with a late rvalid -> ignored; the first fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cm0_pkg.sv
// Shared definitions for the Cortex-M0 fetch path: request FSM encoding,
// Thumb-2 32-bit prefix constants and the halfword width.
package cm0_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  localparam int HW_W = 16;

  localparam logic [4:0] PFX32_A = 5'b11101;
  localparam logic [4:0] PFX32_B = 5'b11110;
  localparam logic [4:0] PFX32_C = 5'b11111;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // A halfword with one of these top-five-bit patterns opens a 32-bit encoding.
  function automatic logic is_32bit_prefix(input logic [HW_W-1:0] hw);
    return (hw[HW_W-1 -: 5] == PFX32_A) ||
           (hw[HW_W-1 -: 5] == PFX32_B) ||
           (hw[HW_W-1 -: 5] == PFX32_C);
  endfunction

endpackage

// File: rtl/fetch_hw_queue.sv
// Circular halfword FIFO: up to two pushes and two pops per cycle,
// synchronous flush, occupancy count.
module fetch_hw_queue
  import cm0_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [1:0]                push_n,
  input  logic [HW_W-1:0]           push_data0,
  input  logic [HW_W-1:0]           push_data1,
  input  logic [1:0]                pop_n,
  output logic [HW_W-1:0]           head0,
  output logic [HW_W-1:0]           head1,
  output logic [$clog2(QDEPTH):0]   count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   wr_ptr_inc;
  logic [PW-1:0]   rd_ptr_inc;
  logic [CW-1:0]   count_reg;
  logic [HW_W-1:0] slots [QDEPTH];

  assign wr_ptr_inc = wr_ptr_reg + PW'(1);
  assign rd_ptr_inc = rd_ptr_reg + PW'(1);

  // Each slot owns its storage; a two-entry push lands in wr_ptr and wr_ptr+1.
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_slot
    logic [HW_W-1:0] slot_reg;
    logic            wr0;
    logic            wr1;

    assign wr0 = (push_n != 2'd0) && (wr_ptr_reg == PW'(gi));
    assign wr1 = (push_n == 2'd2) && (wr_ptr_inc == PW'(gi));

    always_ff @(posedge clk) begin
      if (wr0) begin
        slot_reg <= push_data0;
      end else if (wr1) begin
        slot_reg <= push_data1;
      end
    end

    assign slots[gi] = slot_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(push_n);
      rd_ptr_reg <= rd_ptr_reg + PW'(pop_n);
      count_reg  <= count_reg + CW'(push_n) - CW'(pop_n);
    end
  end

  assign head0 = slots[rd_ptr_reg];
  assign head1 = slots[rd_ptr_inc];
  assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Cortex-M0 instruction fetch stage: word reads into a halfword queue, one
// instruction presented to the decoder. Macro FETCH_BL32_EN pairs 32-bit forms.
module fetch_unit
  import cm0_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        instr_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        instr_is32,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_e    state_reg;
  fetch_state_e    state_next;
  logic [31:0]     addr_reg;
  logic [31:0]     pc_reg;
  logic            skip_low_reg;
  logic            outstanding_reg;
  logic            drop_reg;

  logic [CW-1:0]   count;
  logic [CW-1:0]   free_slots;
  logic [HW_W-1:0] head0;
  logic [HW_W-1:0] head1;
  logic [1:0]      push_n;
  logic [1:0]      pop_n;
  logic [HW_W-1:0] push_data0;
  logic [HW_W-1:0] push_data1;
  logic            granted;
  logic            resp_live;
  logic            accept;
  logic            head_is32;
  logic            pop;
  logic            stale_pending;

  assign granted       = (state_reg == REQ) && imem_gnt;
  // Responses only count while a read is genuinely in flight (covers reset release).
  assign resp_live     = imem_rvalid && outstanding_reg;
  assign accept        = resp_live && !drop_reg && !branch;
  assign free_slots    = CW'(QDEPTH) - count;
  assign stale_pending = granted || (outstanding_reg && !imem_rvalid);

  always_comb begin
    push_n     = 2'd0;
    push_data0 = imem_rdata[15:0];
    push_data1 = imem_rdata[31:16];
    if (accept) begin
      if (skip_low_reg) begin
        push_n     = 2'd1;
        push_data0 = imem_rdata[31:16];
      end else begin
        push_n = 2'd2;
      end
    end
  end

`ifdef FETCH_BL32_EN
  assign head_is32 = is_32bit_prefix(head0);
`else
  assign head_is32 = 1'b0;
`endif

  assign instr_valid = head_is32 ? (count >= CW'(2)) : (count != '0);
  assign instr_is32  = instr_valid && head_is32;
  assign instr       = instr_valid ? {(head_is32 ? head1 : HW_W'(0)), head0} : 32'h0;
  assign pop         = instr_ack && instr_valid && !branch;
  assign pop_n       = pop ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;

  fetch_hw_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch),
    .push_n    (push_n),
    .push_data0(push_data0),
    .push_data1(push_data1),
    .pop_n     (pop_n),
    .head0     (head0),
    .head1     (head1),
    .count     (count)
  );

  always_comb begin
    state_next = state_reg;
    imem_req   = (state_reg == REQ);
    case (state_reg)
      // A new read waits for any discarded read to drain so only one is ever in flight.
      IDLE: if (!branch && !outstanding_reg && free_slots >= CW'(2)) state_next = REQ;
      REQ: begin
        if (branch) begin
          state_next = IDLE;
        end else if (imem_gnt) begin
          state_next = WAIT;
        end
      end
      WAIT: if (branch || imem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      addr_reg        <= RESET_PC & 32'hFFFF_FFFC;
      pc_reg          <= RESET_PC & 32'hFFFF_FFFE;
      skip_low_reg    <= RESET_PC[1];
      outstanding_reg <= 1'b0;
      drop_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (branch) begin
        // A grant taken in the branch cycle still produces a response that must be dropped.
        addr_reg        <= branch_target & 32'hFFFF_FFFC;
        pc_reg          <= branch_target & 32'hFFFF_FFFE;
        skip_low_reg    <= branch_target[1];
        outstanding_reg <= stale_pending;
        drop_reg        <= stale_pending;
      end else begin
        if (granted) begin
          addr_reg        <= addr_reg + 32'd4;
          outstanding_reg <= 1'b1;
        end else if (resp_live) begin
          outstanding_reg <= 1'b0;
          drop_reg        <= 1'b0;
        end
        if (accept) begin
          skip_low_reg <= 1'b0;
        end
        if (pop) begin
          pc_reg <= pc_reg + (head_is32 ? 32'd4 : 32'd2);
        end
      end
    end
  end

  assign imem_addr = addr_reg;
  assign instr_pc  = pc_reg;

endmodule
